// File: rtl/vend_ctrl.sv
// Vending machine sequencer: accumulates coin credit, arbitrates select/cancel, issues
// one-cycle dispense and change commands, and picks the display source. All outputs are registered.
module vend_ctrl #(
    parameter int PRICE_A      = 15,
    parameter int PRICE_B      = 25,
    parameter int MAX_CREDIT   = 50,
    parameter int SHOW_SECS    = 5,
    parameter int TIMEOUT_SECS = 30
) (
    input  logic       vend_clk,
    input  logic       vend_rst_n,
    input  logic       vend_tick,
    input  logic       vend_coin5,
    input  logic       vend_coin10,
    input  logic       vend_sel_a,
    input  logic       vend_sel_b,
    input  logic       vend_cancel,
    output logic [7:0] vend_credit,
    output logic       vend_disp_sel,
    output logic       vend_dispense_a,
    output logic       vend_dispense_b,
    output logic [7:0] vend_change,
    output logic       vend_change_vld,
    output logic       vend_coin_reject,
    output logic       vend_short,
    output logic       vend_busy
);

    localparam int SW = ($clog2(SHOW_SECS + 1) > 3) ? $clog2(SHOW_SECS + 1) : 3;
    localparam int IW = ($clog2(TIMEOUT_SECS + 1) > 1) ? $clog2(TIMEOUT_SECS + 1) : 1;

    localparam logic [7:0]    PRICE_A_L = 8'(PRICE_A);
    localparam logic [7:0]    PRICE_B_L = 8'(PRICE_B);
    localparam logic [8:0]    MAX_L     = 9'(MAX_CREDIT);
    localparam logic [SW-1:0] SHOW_L    = SW'(SHOW_SECS);
    localparam logic [IW-1:0] TMO_LAST  = IW'(TIMEOUT_SECS - 1);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, REFUND} state_t;

    state_t        state_q, state_d;
    logic [7:0]    credit_q, credit_d;
    logic [SW-1:0] show_q, show_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          disp_sel_q, disp_sel_d;
    logic          dispense_a_q, dispense_a_d;
    logic          dispense_b_q, dispense_b_d;
    logic [7:0]    change_q, change_d;
    logic          change_vld_q, change_vld_d;
    logic          reject_q, reject_d;
    logic          short_q, short_d;
    logic          busy_q, busy_d;

    logic [8:0]    coin_amt;
    logic [8:0]    coin_sum;
    logic [7:0]    price;
    logic          user_in;
    logic          coin_ok;
    logic          idle_clr;
    logic          go_refund;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        credit_d     = credit_q;
        show_d       = show_q;
        idle_d       = idle_q;
        dispense_a_d = 1'b0;
        dispense_b_d = 1'b0;
        change_d     = '0;
        change_vld_d = 1'b0;
        reject_d     = 1'b0;
        short_d      = 1'b0;
        coin_ok      = 1'b0;
        idle_clr     = 1'b0;
        go_refund    = 1'b0;

        coin_amt = (vend_coin5 ? 9'd5 : 9'd0) + (vend_coin10 ? 9'd10 : 9'd0);
        coin_sum = {1'b0, credit_q} + coin_amt;
        price    = vend_sel_a ? PRICE_A_L : PRICE_B_L;
        user_in  = vend_sel_a | vend_sel_b | vend_cancel;

        case (state_q)
            IDLE, CREDIT: begin
                if (state_q == CREDIT && vend_cancel) begin
                    go_refund = 1'b1;
                end else if (vend_sel_a || vend_sel_b) begin
                    if (credit_q >= price) begin
                        state_d      = DISPENSE;
                        dispense_a_d = vend_sel_a;
                        dispense_b_d = ~vend_sel_a;
                        if (credit_q > price) begin
                            change_vld_d = 1'b1;
                            change_d     = credit_q - price;
                        end
                    end else begin
                        short_d  = 1'b1;
                        idle_clr = 1'b1;
                    end
                end

                // A coin riding along with any key press is handed back, never credited.
                if (coin_amt != 9'd0) begin
                    if (!user_in && coin_sum <= MAX_L) begin
                        credit_d = coin_sum[7:0];
                        state_d  = CREDIT;
                        show_d   = SHOW_L;
                        idle_clr = 1'b1;
                        coin_ok  = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end

                if (!coin_ok && vend_tick && show_q != '0)
                    show_d = show_q - SW'(1);

                if (state_q == CREDIT && state_d == CREDIT && !go_refund && vend_tick && !idle_clr) begin
                    if (idle_q == TMO_LAST) go_refund = 1'b1;
                    else                    idle_d    = idle_q + IW'(1);
                end

                if (go_refund) begin
                    state_d      = REFUND;
                    change_vld_d = 1'b1;
                    change_d     = credit_q;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                show_d   = '0;
                reject_d = (coin_amt != 9'd0);
            end
        endcase

        if (idle_clr || state_d != state_q) idle_d = '0;
        if (state_d == DISPENSE || state_d == REFUND) show_d = '0;

        busy_d     = (state_d == DISPENSE) || (state_d == REFUND);
        disp_sel_d = (show_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vend_clk or negedge vend_rst_n) begin
        if (!vend_rst_n) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            show_q       <= '0;
            idle_q       <= '0;
            disp_sel_q   <= 1'b1;
            dispense_a_q <= 1'b0;
            dispense_b_q <= 1'b0;
            change_q     <= '0;
            change_vld_q <= 1'b0;
            reject_q     <= 1'b0;
            short_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            show_q       <= show_d;
            idle_q       <= idle_d;
            disp_sel_q   <= disp_sel_d;
            dispense_a_q <= dispense_a_d;
            dispense_b_q <= dispense_b_d;
            change_q     <= change_d;
            change_vld_q <= change_vld_d;
            reject_q     <= reject_d;
            short_q      <= short_d;
            busy_q       <= busy_d;
        end
    end

    assign vend_credit      = credit_q;
    assign vend_disp_sel    = disp_sel_q;
    assign vend_dispense_a  = dispense_a_q;
    assign vend_dispense_b  = dispense_b_q;
    assign vend_change      = change_q;
    assign vend_change_vld  = change_vld_q;
    assign vend_coin_reject = reject_q;
    assign vend_short       = short_q;
    assign vend_busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: fixed vector table, hand-written timer/reset sequences,
// then random stimulus against a transaction-level reference model.
module tb_vend_ctrl;

    localparam int PRICE_A      = 15;
    localparam int PRICE_B      = 25;
    localparam int MAX_CREDIT   = 50;
    localparam int SHOW_SECS    = 5;
    localparam int TIMEOUT_SECS = 30;

    typedef struct packed {
        logic coin5, coin10, sel_a, sel_b, cancel, tick;
    } stim_t;

    typedef struct packed {
        logic [7:0] credit;
        logic       disp_sel, disp_a, disp_b;
        logic [7:0] change;
        logic       change_vld, reject, shrt, busy;
    } outs_t;

    typedef struct {
        stim_t s;
        outs_t o;
    } vec_t;

    logic       vend_clk, vend_rst_n;
    logic       vend_tick, vend_coin5, vend_coin10, vend_sel_a, vend_sel_b, vend_cancel;
    logic [7:0] vend_credit, vend_change;
    logic       vend_disp_sel, vend_dispense_a, vend_dispense_b;
    logic       vend_change_vld, vend_coin_reject, vend_short, vend_busy;

    int n_checks = 0;
    int n_fail   = 0;

    vend_ctrl #(
        .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAX_CREDIT),
        .SHOW_SECS(SHOW_SECS), .TIMEOUT_SECS(TIMEOUT_SECS)
    ) dut (
        .vend_clk(vend_clk), .vend_rst_n(vend_rst_n), .vend_tick(vend_tick),
        .vend_coin5(vend_coin5), .vend_coin10(vend_coin10),
        .vend_sel_a(vend_sel_a), .vend_sel_b(vend_sel_b), .vend_cancel(vend_cancel),
        .vend_credit(vend_credit), .vend_disp_sel(vend_disp_sel),
        .vend_dispense_a(vend_dispense_a), .vend_dispense_b(vend_dispense_b),
        .vend_change(vend_change), .vend_change_vld(vend_change_vld),
        .vend_coin_reject(vend_coin_reject), .vend_short(vend_short), .vend_busy(vend_busy)
    );

    initial vend_clk = 1'b0;
    always #5 vend_clk = ~vend_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: credit in plain jiao, seconds left on the credit display,
    // idle seconds counted, and whether this cycle is the dispense/refund cycle.
    int    m_credit, m_show, m_idle;
    bit    m_busy;
    outs_t m_exp;

    function automatic void model_reset();
        m_credit = 0; m_show = 0; m_idle = 0; m_busy = 0;
    endfunction

    function automatic void model_step(input stim_t s);
        int amount, price;
        bit user_in, loaded, quiet, leave;
        amount  = (s.coin5 ? 5 : 0) + (s.coin10 ? 10 : 0);
        user_in = s.sel_a | s.sel_b | s.cancel;
        loaded  = 0; quiet = 0; leave = 0;
        m_exp   = '0;
        if (m_busy) begin
            m_busy = 0; m_credit = 0; m_show = 0; m_idle = 0;
            m_exp.reject = (amount != 0);
        end else begin
            if (s.cancel && m_credit > 0) begin
                leave = 1;
                m_exp.change_vld = 1;
                m_exp.change     = 8'(m_credit);
            end else if (s.sel_a || s.sel_b) begin
                price = s.sel_a ? PRICE_A : PRICE_B;
                if (m_credit >= price) begin
                    leave = 1;
                    m_exp.disp_a = s.sel_a;
                    m_exp.disp_b = !s.sel_a;
                    if (m_credit > price) begin
                        m_exp.change_vld = 1;
                        m_exp.change     = 8'(m_credit - price);
                    end
                end else begin
                    m_exp.shrt = 1;
                    quiet      = 1;
                    m_idle     = 0;
                end
            end
            if (amount != 0) begin
                if (!user_in && m_credit + amount <= MAX_CREDIT) begin
                    m_credit += amount; m_show = SHOW_SECS; m_idle = 0; loaded = 1;
                end else begin
                    m_exp.reject = 1;
                end
            end
            if (!leave && s.tick && !loaded) begin
                if (m_show > 0) m_show--;
                if (!quiet && m_credit > 0) begin
                    m_idle++;
                    if (m_idle >= TIMEOUT_SECS) begin
                        leave = 1;
                        m_exp.change_vld = 1;
                        m_exp.change     = 8'(m_credit);
                    end
                end
            end
            if (leave) begin
                m_busy = 1; m_show = 0; m_idle = 0;
            end
        end
        m_exp.credit   = 8'(m_credit);
        m_exp.disp_sel = (m_show == 0);
        m_exp.busy     = m_busy;
    endfunction

    function automatic stim_t st(bit c5, bit c10, bit sa, bit sb, bit cn, bit tk);
        stim_t s;
        s = '{coin5: c5, coin10: c10, sel_a: sa, sel_b: sb, cancel: cn, tick: tk};
        return s;
    endfunction

    function automatic outs_t ex(int credit, bit dsel, bit da, bit db, int chg,
                                 bit vld, bit rej, bit sht, bit busy);
        outs_t o;
        o = '{credit: 8'(credit), disp_sel: dsel, disp_a: da, disp_b: db, change: 8'(chg),
              change_vld: vld, reject: rej, shrt: sht, busy: busy};
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all(input outs_t e, input string tag);
        check({tag, " credit"},     int'(vend_credit),      int'(e.credit));
        check({tag, " disp_sel"},   int'(vend_disp_sel),    int'(e.disp_sel));
        check({tag, " dispense_a"}, int'(vend_dispense_a),  int'(e.disp_a));
        check({tag, " dispense_b"}, int'(vend_dispense_b),  int'(e.disp_b));
        check({tag, " change"},     int'(vend_change),      int'(e.change));
        check({tag, " change_vld"}, int'(vend_change_vld),  int'(e.change_vld));
        check({tag, " coin_reject"},int'(vend_coin_reject), int'(e.reject));
        check({tag, " short"},      int'(vend_short),       int'(e.shrt));
        check({tag, " busy"},       int'(vend_busy),        int'(e.busy));
    endtask

    task automatic apply(input stim_t s);
        vend_coin5  = s.coin5;  vend_coin10 = s.coin10;
        vend_sel_a  = s.sel_a;  vend_sel_b  = s.sel_b;
        vend_cancel = s.cancel; vend_tick   = s.tick;
    endtask

    // One clock with the model as reference; outputs sampled 1 time unit after the edge.
    task automatic cycle(input stim_t s, input string tag);
        apply(s);
        model_step(s);
        @(posedge vend_clk);
        #1;
        compare_all(m_exp, tag);
    endtask

    vec_t tbl[$];

    task automatic add(input stim_t s, input outs_t o);
        tbl.push_back('{s, o});
    endtask

    initial begin
        stim_t s;
        int    d;
        vend_rst_n = 1'b0;
        apply(st(0,0,0,0,0,0));
        model_reset();
        repeat (2) @(posedge vend_clk);
        #1;
        compare_all(ex(0,1,0,0,0,0,0,0,0), "reset");
        @(negedge vend_clk);
        vend_rst_n = 1'b1;

        // st(coin5, coin10, sel_a, sel_b, cancel, tick)
        // ex(credit, disp_sel, disp_a, disp_b, change, change_vld, reject, short, busy)
        add(st(0,1,0,0,0,0), ex(10,0,0,0, 0,0,0,0,0));
        add(st(1,0,0,0,0,0), ex(15,0,0,0, 0,0,0,0,0));
        add(st(0,0,1,0,0,0), ex(15,1,1,0, 0,0,0,0,1));
        add(st(0,0,0,0,0,0), ex( 0,1,0,0, 0,0,0,0,0));
        add(st(0,1,0,0,0,0), ex(10,0,0,0, 0,0,0,0,0));
        add(st(0,1,0,0,0,0), ex(20,0,0,0, 0,0,0,0,0));
        add(st(0,1,0,0,0,0), ex(30,0,0,0, 0,0,0,0,0));
        add(st(0,0,0,1,0,0), ex(30,1,0,1, 5,1,0,0,1));
        add(st(0,0,0,0,0,0), ex( 0,1,0,0, 0,0,0,0,0));
        add(st(0,1,0,0,0,0), ex(10,0,0,0, 0,0,0,0,0));
        add(st(0,0,0,1,0,0), ex(10,0,0,0, 0,0,0,1,0));
        add(st(0,0,1,0,1,0), ex(10,1,0,0,10,1,0,0,1));
        add(st(0,0,0,0,0,0), ex( 0,1,0,0, 0,0,0,0,0));
        add(st(0,0,1,0,0,0), ex( 0,1,0,0, 0,0,0,1,0));
        add(st(0,0,0,0,1,0), ex( 0,1,0,0, 0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            add(st(0,1,0,0,0,0), ex(10 * (i + 1),0,0,0,0,0,0,0,0));
        add(st(1,0,0,0,0,0), ex(45,0,0,0, 0,0,0,0,0));
        add(st(1,1,0,0,0,0), ex(45,0,0,0, 0,0,1,0,0));
        add(st(1,0,0,0,0,0), ex(50,0,0,0, 0,0,0,0,0));
        add(st(1,0,0,0,0,0), ex(50,0,0,0, 0,0,1,0,0));
        add(st(0,0,0,0,1,0), ex(50,1,0,0,50,1,0,0,1));
        add(st(0,0,0,0,0,0), ex( 0,1,0,0, 0,0,0,0,0));
        add(st(0,1,0,0,0,0), ex(10,0,0,0, 0,0,0,0,0));
        add(st(1,0,0,0,0,0), ex(15,0,0,0, 0,0,0,0,0));
        add(st(0,1,1,0,0,0), ex(15,1,1,0, 0,0,1,0,1));
        add(st(1,0,0,0,0,0), ex( 0,1,0,0, 0,0,1,0,0));
        add(st(0,0,0,0,0,0), ex( 0,1,0,0, 0,0,0,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i].s);
            model_step(tbl[i].s);
            @(posedge vend_clk);
            #1;
            compare_all(tbl[i].o, $sformatf("tbl[%0d]", i));
        end

        // Credit display: five ticks after a coin, then a reload on the third tick.
        cycle(st(1,0,0,0,0,0), "show coin");
        for (int k = 1; k <= 5; k++) begin
            cycle(st(0,0,0,0,0,0), "show gap");
            check("show before tick", int'(vend_disp_sel), 0);
            cycle(st(0,0,0,0,0,1), "show tick");
            check($sformatf("show after tick %0d", k), int'(vend_disp_sel), (k < 5) ? 0 : 1);
        end
        cycle(st(1,0,0,0,0,0), "reload coin");
        cycle(st(0,0,0,0,0,1), "reload tick1");
        cycle(st(0,0,0,0,0,1), "reload tick2");
        cycle(st(1,0,0,0,0,1), "reload coin+tick3");
        check("reload credit", int'(vend_credit), 15);
        for (int k = 1; k <= 5; k++) begin
            cycle(st(0,0,0,0,0,1), "reload tick");
            check($sformatf("reload after tick %0d", k), int'(vend_disp_sel), (k < 5) ? 0 : 1);
        end
        cycle(st(0,0,0,0,1,0), "show cancel");
        cycle(st(0,0,0,0,0,0), "show idle");

        // Inactivity refund after exactly TIMEOUT_SECS ticks.
        cycle(st(0,1,0,0,0,0), "tmo coin");
        for (int k = 1; k < TIMEOUT_SECS; k++) cycle(st(0,0,0,0,0,1), "tmo tick");
        check("tmo not yet busy", int'(vend_busy), 0);
        cycle(st(0,0,0,0,0,1), "tmo last tick");
        check("tmo change_vld", int'(vend_change_vld), 1);
        check("tmo change", int'(vend_change), 10);
        cycle(st(0,0,0,0,0,0), "tmo end");
        check("tmo credit cleared", int'(vend_credit), 0);

        // Timeout tick coinciding with a short selection: the selection wins.
        cycle(st(0,1,0,0,0,0), "tmo2 coin");
        for (int k = 1; k < TIMEOUT_SECS; k++) cycle(st(0,0,0,0,0,1), "tmo2 tick");
        cycle(st(0,0,0,1,0,1), "tmo2 sel_b+tick");
        check("tmo2 short", int'(vend_short), 1);
        check("tmo2 no refund", int'(vend_change_vld), 0);
        cycle(st(0,0,0,0,0,1), "tmo2 after");
        check("tmo2 still credit", int'(vend_credit), 10);
        cycle(st(0,0,0,0,1,0), "tmo2 cancel");
        cycle(st(0,0,0,0,0,0), "tmo2 idle");

        // Reset in the middle of a refund drops everything at once.
        cycle(st(1,0,0,0,0,0), "rst coin");
        cycle(st(0,0,0,0,1,0), "rst cancel");
        #2;
        vend_rst_n = 1'b0;
        apply(st(0,0,0,0,0,0));
        #1;
        compare_all(ex(0,1,0,0,0,0,0,0,0), "rst async");
        model_reset();
        @(negedge vend_clk);
        vend_rst_n = 1'b1;
        cycle(st(0,0,0,0,0,0), "rst after");

        // Random traffic: a busy phase, then a sparse phase that lets refunds time out.
        for (int ph = 0; ph < 2; ph++) begin
            d = (ph == 0) ? 5 : 150;
            for (int i = 0; i < ((ph == 0) ? 2000 : 3000); i++) begin
                s.coin5  = ($urandom_range(d - 1) == 0);
                s.coin10 = ($urandom_range(d - 1) == 0);
                s.sel_a  = ($urandom_range(d - 1) == 0);
                s.sel_b  = ($urandom_range(d - 1) == 0);
                s.cancel = ($urandom_range(d - 1) == 0);
                s.tick   = ($urandom_range((ph == 0) ? 2 : 1) == 0);
                cycle(s, $sformatf("rand%0d[%0d]", ph, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Central sequencer for the vending machine. It accumulates coin credit, arbitrates the two product select keys and cancel, and issues one-cycle dispense and change commands. It also drives the display source select: credit is shown for SHOW_SECS seconds after each accepted coin, otherwise the price view is shown. Unused credit is refunded after TIMEOUT_SECS seconds of inactivity. It sits between the debounced key/coin front end and the display mux and dispenser drivers.

Parameters:
PRICE_A, 15, product A price in jiao (0.1 yuan units)
PRICE_B, 25, product B price in jiao
MAX_CREDIT, 50, credit ceiling in jiao (must be <=255)
SHOW_SECS, 5, seconds credit stays on display after an accepted coin
TIMEOUT_SECS, 30, idle seconds in CREDIT before auto-refund

Ports:
vend_clk  in  1  system clock, all logic on rising edge
vend_rst_n  in  1  reset, asynchronous assert, active-low
vend_tick  in  1  1 Hz strobe, exactly one vend_clk cycle wide
vend_coin5  in  1  0.5-yuan coin accepted pulse, one cycle
vend_coin10  in  1  1-yuan coin accepted pulse, one cycle
vend_sel_a  in  1  select product A pulse, one cycle
vend_sel_b  in  1  select product B pulse, one cycle
vend_cancel  in  1  cancel/refund pulse, one cycle
vend_credit  out  8  current credit in jiao
vend_disp_sel  out  1  0 = show credit, 1 = show price view
vend_dispense_a  out  1  one-cycle dispense command, product A
vend_dispense_b  out  1  one-cycle dispense command, product B
vend_change  out  8  change/refund amount in jiao, valid with vend_change_vld
vend_change_vld  out  1  one-cycle change command
vend_coin_reject  out  1  one-cycle pulse: coin(s) returned, not credited
vend_short  out  1  one-cycle pulse: selection with insufficient credit
vend_busy  out  1  high in DISPENSE or REFUND

Behaviour:
- Reset sets state IDLE and all outputs and counters to 0, except vend_disp_sel = 1. Reset mid-operation drops any pending dispense or refund; credit is lost.
- All outputs are registered. Pulses last exactly one cycle.
- States:
  - IDLE: credit = 0.
  - CREDIT: credit > 0.
  - DISPENSE: one cycle.
  - REFUND: one cycle.
- Coins (IDLE/CREDIT): the amount is 5 * coin5 + 10 * coin10; both may arrive in the same cycle.
  - If credit + amount <= MAX_CREDIT: add at the next edge and go to CREDIT.
  - Otherwise: assert vend_coin_reject and leave credit unchanged. Both coins are rejected together.
  - Use a 9-bit sum for the compare.
- Priority in CREDIT, same cycle: cancel > sel_a > sel_b. Any coin arriving in a cycle with sel or cancel is rejected.
- Selection (sel sampled at edge N):
  - If credit >= price: go to DISPENSE at N+1 and assert dispense_x.
  - In that same cycle, if credit > price, assert vend_change_vld with vend_change = credit - price.
  - At N+2: state IDLE, credit 0.
  - If credit < price: assert vend_short at N+1; state and credit unchanged.
  - Selection in IDLE asserts vend_short.
- Cancel (CREDIT): go to REFUND at N+1 with vend_change_vld = 1 and vend_change = credit. At N+2: IDLE, credit 0. Cancel in IDLE is ignored.
- Inputs during DISPENSE/REFUND: coins are rejected; sel and cancel are ignored.
- Show timer (3 bits+):
  - Each accepted coin loads SHOW_SECS.
  - Decrement on vend_tick while nonzero.
  - vend_disp_sel = (show timer == 0).
  - DISPENSE/REFUND clear the timer.
  - Load beats a decrement in the same cycle.
- Inactivity timer:
  - Cleared on any accepted coin, short selection or state change.
  - Increments on vend_tick in CREDIT.
  - On reaching TIMEOUT_SECS, go to REFUND exactly as a cancel would.
  - A timeout tick coinciding with sel or cancel: the user input wins.
- vend_credit is held at 0 in IDLE.

Test Plan:
- Reset mid-REFUND: assert vend_rst_n=0 -> all outputs 0 immediately, vend_disp_sel=1, state IDLE.
- coin10, coin5, sel_a -> credit 10 then 15; dispense_a at N+1; no change_vld; credit 0 at N+2.
- coin10 x3, sel_b -> dispense_b and change_vld with change=5 in the same cycle; credit 0 next cycle.
- Credit 45, coin5 + coin10 same cycle -> coin_reject pulse, credit stays 45. Then coin5 -> credit 50.
- Coin then 5 ticks -> disp_sel=0 through the 5th tick, =1 after it. A second coin at tick 3 reloads to 5.
- Credit 10, sel_b -> short pulse, credit 10. No input for 30 ticks -> REFUND with change=10. Cancel + sel_a same cycle -> REFUND, no dispense.
